// File: rtl/mult_share_arb.sv
// Round-robin sharing of one external pipelined multiplier among NREQ requesters.
// Define MULT_SHARE_ARB_PERF_EN to add issue/stall counters and a pipeline occupancy output.
module mult_share_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 20,
  parameter int unsigned MULT_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*AW-1:0]     req_a,
  input  logic [NREQ*AW-1:0]     req_b,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*2*AW-1:0]   rsp_p,
  output logic [AW-1:0]          mult_a,
  output logic [AW-1:0]          mult_b,
  input  logic [2*AW-1:0]        mult_p
`ifdef MULT_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]                    issue_cnt,
  output logic [31:0]                    stall_cnt,
  output logic [$clog2(MULT_LAT+2)-1:0]  occupancy
`endif
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]              busy_q;
  logic [NREQ-1:0]              eligible;
  logic [NREQ-1:0]              grant;
  logic [IDW-1:0]               ptr_q;
  logic [IDW-1:0]               grant_id;
  logic                         found;
  logic                         issue;
  logic [MULT_LAT:0]            tag_vld_q;
  logic [MULT_LAT:0][IDW-1:0]   tag_id_q;
  logic                         cap;
  logic [IDW-1:0]               cap_id;
  logic [NREQ-1:0]              rsp_valid_q;
  logic [NREQ*2*AW-1:0]         rsp_p_q;
  logic [AW-1:0]                mult_a_q;
  logic [AW-1:0]                mult_b_q;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign eligible = req_valid & ~busy_q;

  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && eligible[wrap_idx(ptr_q, k)]) begin
        found    = 1'b1;
        grant_id = wrap_idx(ptr_q, k);
      end
    end
  end

  // Gate with rst_n so req_ready is zero for the whole reset, not just after the first edge.
  always_comb begin
    grant = '0;
    if (found && rst_n) grant[grant_id] = 1'b1;
  end

  assign issue     = |grant;
  assign req_ready = grant;
  assign cap       = tag_vld_q[MULT_LAT];
  assign cap_id    = tag_id_q[MULT_LAT];
  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = rsp_p_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_p_q     <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
    end else begin
      if (issue) begin
        mult_a_q <= req_a[32'(grant_id)*AW +: AW];
        mult_b_q <= req_b[32'(grant_id)*AW +: AW];
        ptr_q    <= wrap_idx(grant_id, 1);
      end
      // Tag at stage MULT_LAT lines up with mult_p for the operands issued MULT_LAT+1 edges ago.
      tag_vld_q[0] <= issue;
      tag_id_q[0]  <= grant_id;
      for (int unsigned k = 1; k <= MULT_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (issue && grant_id == IDW'(i)) begin
          busy_q[i] <= 1'b1;
        end else if (rsp_valid_q[i] && rsp_ready[i]) begin
          busy_q[i] <= 1'b0;
        end
        if (cap && cap_id == IDW'(i)) begin
          rsp_valid_q[i]              <= 1'b1;
          rsp_p_q[i*2*AW +: 2*AW]     <= mult_p;
        end else if (rsp_valid_q[i] && rsp_ready[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef MULT_SHARE_ARB_PERF_EN
  localparam int unsigned OCW = $clog2(MULT_LAT+2);

  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (issue) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (|(req_valid & ~grant)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k <= MULT_LAT; k++) begin
      occupancy = occupancy + OCW'(tag_vld_q[k]);
    end
  end

  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb: randomized traffic against a round-robin reference model,
// with an external one-stage multiplier model driving mult_p.
module tb_mult_share_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 20;
  localparam int unsigned ML   = 1;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*AW-1:0]    req_a;
  logic [NREQ*AW-1:0]    req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [NREQ*2*AW-1:0]  rsp_p;
  logic [AW-1:0]         mult_a;
  logic [AW-1:0]         mult_b;
  logic [2*AW-1:0]       mult_p;
`ifdef MULT_SHARE_ARB_PERF_EN
  logic [31:0]              issue_cnt;
  logic [31:0]              stall_cnt;
  logic [$clog2(ML+2)-1:0]  occupancy;
`endif

  mult_share_arb #(.NREQ(NREQ), .AW(AW), .MULT_LAT(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p)
`ifdef MULT_SHARE_ARB_PERF_EN
    ,
    .issue_cnt (issue_cnt),
    .stall_cnt (stall_cnt),
    .occupancy (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*AW-1:0] mul(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [2*AW-1:0] aa;
    logic [2*AW-1:0] bb;
    aa = '0;
    bb = '0;
    aa[AW-1:0] = a;
    bb[AW-1:0] = b;
    return aa * bb;
  endfunction

  // External multiplier: ML register stages.
  logic [2*AW-1:0] p_pipe [ML];
  always @(posedge clk) begin
    p_pipe[0] <= mul(mult_a, mult_b);
    for (int k = 1; k < ML; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mult_p = p_pipe[ML-1];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  typedef struct {
    int              id;
    logic [2*AW-1:0] p;
    int              due;
  } sb_entry_t;

  sb_entry_t       sb[$];
  int              m_ptr = 0;
  bit [NREQ-1:0]   m_out = '0;
  bit [NREQ-1:0]   seen  = '0;
  logic [2*AW-1:0] held [NREQ];
  int              n_issue = 0;
  int              n_stall = 0;
  int              occ_max = 0;

  // Monitor: model predicts grants and pushes expected products; results are popped on arrival.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_mult_ab", 64'({mult_a, mult_b}), 64'd0);
      chk("reset_rsp_p_zero", 64'(rsp_p == '0), 64'd1);
      sb.delete();
      m_ptr   = 0;
      m_out   = '0;
      seen    = '0;
      n_issue = 0;
      n_stall = 0;
    end else begin
      int            g;
      logic [NREQ-1:0] exp_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx] && !m_out[idx]) g = idx;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (|(req_valid & ~exp_ready)) n_stall++;
      if (g >= 0) begin
        sb_entry_t e;
        e.id  = g;
        e.p   = mul(req_a[g*AW +: AW], req_b[g*AW +: AW]);
        e.due = cyc + ML + 2;
        sb.push_back(e);
        m_out[g] = 1'b1;
        m_ptr    = (g + 1) % NREQ;
        n_issue++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && !seen[i]) begin
          int hit;
          hit = -1;
          foreach (sb[j]) if (hit < 0 && sb[j].id == i) hit = j;
          if (hit < 0) begin
            chk("spurious_rsp", 64'(rsp_valid[i]), 64'd0);
          end else begin
            chk("rsp_p", 64'(rsp_p[i*2*AW +: 2*AW]), 64'(sb[hit].p));
            chk("rsp_latency", 64'(cyc), 64'(sb[hit].due));
            sb.delete(hit);
          end
          seen[i] = 1'b1;
          held[i] = rsp_p[i*2*AW +: 2*AW];
        end else if (rsp_valid[i]) begin
          chk("rsp_p_hold", 64'(rsp_p[i*2*AW +: 2*AW]), 64'(held[i]));
        end
        if (rsp_valid[i] && rsp_ready[i]) begin
          seen[i]  = 1'b0;
          m_out[i] = 1'b0;
        end
      end
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].due < cyc) begin
          chk("rsp_timeout", 64'(rsp_valid[sb[j].id]), 64'd1);
          sb.delete(j);
        end
      end
`ifdef MULT_SHARE_ARB_PERF_EN
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
`endif
    end
  end

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[i] && n < 50);
    if (!req_ready[i]) chk("grant_timeout", 64'(req_ready[i]), 64'd1);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*AW +: AW] = ($urandom % 8 == 0) ? '1 : AW'($urandom);
      req_b[i*AW +: AW] = ($urandom % 8 == 0) ? '1 : AW'($urandom);
    end
  endtask

  task automatic phase(input int n, input bit all_valid, input logic [NREQ-1:0] rdy_mask,
                       input bit rand_rdy);
    repeat (n) begin
      @(posedge clk);
      #1;
      rand_ops();
      req_valid = all_valid ? '1 : NREQ'($urandom);
      rsp_ready = rand_rdy ? (NREQ'($urandom) & rdy_mask) : rdy_mask;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op on requester 2, max operands.
    @(posedge clk);
    #1;
    req_a[2*AW +: AW] = 20'hFFFFF;
    req_b[2*AW +: AW] = 20'hFFFFF;
    req_valid = 4'b0100;
    wait_grant(2);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("single_valid", 64'(rsp_valid[2]), 64'd1);
    chk("single_p", 64'(rsp_p[2*2*AW +: 2*AW]), 64'hFF_FFE0_0001);

    // Back-to-back from requesters 0 and 1.
    @(posedge clk);
    #1;
    req_a[0 +: AW] = 20'd3;
    req_b[0 +: AW] = 20'd5;
    req_valid = 4'b0001;
    wait_grant(0);
    @(posedge clk);
    #1;
    req_a[AW +: AW] = 20'd7;
    req_b[AW +: AW] = 20'd9;
    req_valid = 4'b0010;
    wait_grant(1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("b2b_p0", 64'(rsp_p[0 +: 2*AW]), 64'd15);
    chk("b2b_p1", 64'(rsp_p[2*AW +: 2*AW]), 64'd63);

    // Fairness, backpressure on requester 1, then fully random traffic.
    phase(40, 1'b1, '1, 1'b0);
    phase(30, 1'b1, 4'b1101, 1'b0);
    phase(10, 1'b1, '1, 1'b0);
    phase(400, 1'b0, '1, 1'b1);

    // Reset while requester 3 is in flight.
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (6) @(posedge clk);
    #1;
    req_a[3*AW +: AW] = 20'd100;
    req_b[3*AW +: AW] = 20'd200;
    req_valid = 4'b1000;
    wait_grant(3);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    phase(12, 1'b1, '1, 1'b0);

    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
`ifdef MULT_SHARE_ARB_PERF_EN
    chk("issue_cnt", 64'(issue_cnt), 64'(n_issue));
    chk("stall_cnt", 64'(stall_cnt), 64'(n_stall));
    chk("occupancy_peak", 64'(occ_max), 64'd2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined 20x20 unsigned multiplier among NREQ requesters.
- Each requester has a valid/ready operand port and a valid/ready result port.
- The block owns the multiplier operand registers, tracks in-flight operations with a tag pipeline, and returns each product to the requester that issued it.
- It sits between the client datapaths and a single multiplier instance (40-bit product, MULT_LAT register stages).

Parameters:
- NREQ, 4: number of requesters (2..8).
- AW, 20: operand width.
- MULT_LAT, 1: cycles from mult_a/mult_b change to a valid mult_p.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  operand request per requester.
- req_ready  out  NREQ  grant; one-hot or zero.
- req_a  in  NREQ*AW  operand A; slice i = bits [i*AW +: AW].
- req_b  in  NREQ*AW  operand B; same slicing.
- rsp_valid  out  NREQ  result held for requester i.
- rsp_ready  in  NREQ  requester i accepts its result.
- rsp_p  out  NREQ*2*AW  product; slice i = bits [i*2*AW +: 2*AW].
- mult_a  out  AW  registered operand to the multiplier.
- mult_b  out  AW  registered operand to the multiplier.
- mult_p  in  2*AW  product from the multiplier.

Behaviour:
- Reset (async assert, sync release): req_ready, rsp_valid, busy, tag pipeline valids, mult_a, mult_b, rsp_p all 0; RR pointer = 0.
- Reset mid-operation discards all in-flight products; nothing is delivered after release.
- Eligible set: req_valid[i] & ~busy[i], where busy[i] is a registered flag. Each requester has at most one operation outstanding.
- Arbitration is combinational round-robin from pointer ptr:
  - Grant the first eligible index at or after ptr, wrapping at NREQ-1 -> 0.
  - req_ready = one-hot grant, or 0 if none eligible.
  - At most one issue per cycle.
- Issue at edge E0 (req_valid[g] & req_ready[g]):
  - mult_a <= req_a[g], mult_b <= req_b[g].
  - busy[g] <= 1.
  - ptr <= (g+1) mod NREQ.
  - Tag {valid=1, id=g} enters stage 0 of the tag shift pipeline, depth MULT_LAT+1.
- No issue: mult_a/mult_b hold their values, a bubble (valid=0) enters the pipeline, and ptr holds.
- Capture: when the tag exits the pipeline (edge E0+MULT_LAT+1), rsp_p[id] <= mult_p and rsp_valid[id] <= 1.
- Latency: rsp_valid rises MULT_LAT+1 cycles after the issue handshake (2 cycles at default). Back-to-back issues from different requesters produce one capture per cycle.
- Result handshake:
  - rsp_valid[i] & rsp_ready[i] at an edge clears rsp_valid[i] and busy[i].
  - rsp_p[i] holds its value until the next capture.
  - The earliest reissue from i is the cycle after its result handshake.
- Capture and result handshake never coincide for the same requester, because busy prevents a second issue.
- A requester with rsp_valid high and rsp_ready low stalls only itself. The others continue to be granted.
- Arithmetic is unsigned; the product is full 2*AW bits with no truncation.
- Widths: the id field is clog2(NREQ) bits, minimum 1.
- req_valid deasserted with no handshake is allowed; no request is lost or duplicated.

Optional Feature:
- Macro: MULT_SHARE_ARB_PERF_EN.
- When defined, three extra outputs are added:
  - issue_cnt: 32-bit issue counter, incremented on every issue handshake, wraps.
  - stall_cnt: 32-bit stall counter, incremented each cycle in which some req_valid[i] is high but req_ready[i] is low, wraps.
  - occupancy: clog2(MULT_LAT+2)-bit count of valid tags in the pipeline.
- The counters reset to 0 on rst_n.
- When not defined, these ports and registers do not exist and the core behaviour is identical.

Test Plan:
- Single op: requester 2, A=20'hFFFFF, B=20'hFFFFF, rsp_ready=1 -> rsp_valid[2] is high exactly 2 cycles after the handshake, rsp_p slice 2 = 40'hFFFFE00001, busy clears.
- Fairness: all four req_valid held high with rsp_ready=1 -> grants in the order 0,1,2,3,0,... and exactly one req_ready bit per cycle.
- Back-to-back: req 0 (3x5) then req 1 (7x9) on consecutive cycles -> rsp_valid[0]=1 with product 15 at cycle t+2, rsp_valid[1]=1 with product 63 at cycle t+3, no cross-delivery.
- Backpressure: rsp_ready[1]=0 after req 1 issues 12x12 -> req_ready[1] stays 0 while req 0 and req 3 keep issuing. rsp_p slice 1 holds 144 until rsp_ready[1]=1, then req 1 may be granted the next cycle.
- Reset mid-flight: issue req 3 (100x200), pull rst_n low 1 cycle after issue -> all outputs 0 immediately. After release no rsp_valid for 10 cycles and ptr restarts at 0.
- Perf (macro defined): 5 issues plus 3 stall cycles -> issue_cnt=5, stall_cnt=3; occupancy peaks at 2 with MULT_LAT=1.
